exception_unit: RTL and testbench
=================================

Name: exception_unit

Overview:
- MEM-stage exception arbiter sitting directly upstream of the CP0 register block.
- Gathers raw per-instruction exception flags and checks pending, enabled interrupts against forwarded Status/Cause. Picks one winner by priority and presents it to CP0 for exactly one cycle.
- Flushes the pipeline and drives a valid/ready redirect to IF: exception vector for exceptions, EPC for eret.

Parameters:
EXC_VECTOR, 32'hBFC0_0380, redirect target for all exceptions and interrupts
TIMER_IP_BIT, 15, Cause bit into which the CP0 timer interrupt is ORed

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
MemValid_i  in  1  MEM stage holds a valid instruction
ExceptType_i  in  ExceptinPipeType  raw exception flags of the MEM instruction
MemPC_i  in  32  PC of the MEM instruction
IsDelaySlot_i  in  1  MEM instruction is in a delay slot
MemVAddr_i  in  32  data virtual address of the MEM instruction
CP0Status_i  in  32  current CP0 Status
CP0Cause_i  in  32  current CP0 Cause
CP0EPC_i  in  32  current CP0 EPC
CP0TimerInterrupt_i  in  1  timer interrupt from CP0
CP0Wr_i  in  1  mtc0 write in flight (same cycle as CP0 write port)
CP0WrAddr_i  in  5  mtc0 destination register
CP0WrData_i  in  32  mtc0 data
RedirectReady_i  in  1  IF accepts the redirect
ExceptTypeFinal_o  out  ExceptinPipeType  one-hot winning exception to CP0
IsDelaySlot_o  out  1  delay-slot flag to CP0
PCAdd4_o  out  32  faulting PC + 4 (CP0 subtracts 4)
VirtualAddr_o  out  32  BadVAddr candidate to CP0
Flush_o  out  1  flush IF..MEM
RedirectValid_o  out  1  redirect request to IF
RedirectPC_o  out  32  redirect target
Stall_o  out  1  hold IF while redirect is pending

Behaviour:
- Reset: all outputs 0; ExceptTypeFinal_o all fields 0; state IDLE.
- Forwarding:
  - Effective Status = CP0WrData_i when CP0Wr_i and addr 12, else CP0Status_i.
  - Effective EPC likewise for addr 14.
  - Effective Cause[9:8] likewise for addr 13.
- Interrupt pending when all of the following hold:
  - (IP & IM) != 0, where IP = Cause[15:8] with CP0TimerInterrupt_i ORed into TIMER_IP_BIT, and IM = Status[15:8].
  - Status.IE (bit 0) = 1.
  - Status.EXL (bit 1) = 0.
  - MemValid_i = 1.
- Priority, highest first: Interrupt, WrongAddressinIF, ReservedInstruction, Overflow, Syscall, Break, RdWrongAddressinMEM, WrWrongAddressinMEM, Eret. Exactly one bit is set in the output.
- Gating: flags are ignored when MemValid_i = 0 or state != IDLE.
- FSM IDLE:
  - Winner found in cycle N: at the edge ending N, register ExceptTypeFinal_o, IsDelaySlot_o, PCAdd4_o = MemPC_i + 4 (mod 2^32), VirtualAddr_o.
  - VirtualAddr_o = MemPC_i for IF address errors, else MemVAddr_i.
  - Flush_o = 1, RedirectValid_o = 1, Stall_o = 1 in cycle N+1. Go to REDIRECT.
  - RedirectPC_o = EXC_VECTOR, or effective EPC captured in cycle N for Eret.
- FSM REDIRECT:
  - ExceptTypeFinal_o and Flush_o return to 0 after one cycle.
  - RedirectValid_o, RedirectPC_o and Stall_o hold until RedirectReady_i = 1. On that cycle's edge they clear and the FSM returns to IDLE.
  - Ready in N+1 gives total latency 1 and IDLE in N+2.
- Corner cases:
  - Redirect handshake follows valid/ready semantics: RedirectPC_o is stable while valid.
  - A new exception arriving during REDIRECT is dropped; the pipeline is flushed.
  - Interrupt together with a synchronous exception on the same instruction: Interrupt wins.
  - mtc0 clearing IE in the same cycle as a pending interrupt: no interrupt (forwarded value wins).
  - rst asserted mid-REDIRECT: next edge forces IDLE with all outputs 0.

Decomposition:
- Shared package (CPU_Defines.svh):
  - ExceptinPipeType (existing).
  - New enum exc_state_t {EXC_IDLE, EXC_REDIRECT}.
  - Status bit-index constants: IE, EXL, IM range.
  - EXC_VECTOR default value.
  - ExcCode constants, shared with CP0.
- One combinational sub-module, exc_prioritizer: raw flags + interrupt pending -> one-hot winner + is_eret.

Test Plan:
- Status = 32'h0000_FF01, Cause[10] = 1, MemValid_i = 1, PC 32'h8000_0100 -> next cycle Interrupt one-hot, PCAdd4_o = 32'h8000_0104, Flush_o 1 cycle, RedirectPC_o = 32'hBFC0_0380.
- Syscall + Overflow together, IsDelaySlot_i = 1 -> only Overflow set, IsDelaySlot_o = 1.
- RdWrongAddressinMEM, MemVAddr_i = 32'h0000_0003 -> VirtualAddr_o = 3. WrongAddressinIF at PC 32'h8000_0002 -> VirtualAddr_o = 32'h8000_0002.
- Eret with mtc0 EPC = 32'h8000_0200 in the same cycle -> RedirectPC_o = 32'h8000_0200, not the stale CP0EPC_i.
- RedirectReady_i low for 3 cycles -> RedirectValid_o/Stall_o held 4 cycles with stable PC; a Break raised meanwhile is ignored.
- Pending interrupt with EXL = 1, or with mtc0 Status IE = 0 in the same cycle -> no exception, Flush_o stays 0.

Source files
------------

// File: rtl/exception_unit_pkg.sv
// Shared definitions for the MEM-stage exception arbiter and CP0.
// Exception flag layout, FSM states, Status/Cause bit positions and ExcCodes.
package exception_unit_pkg;

    typedef struct packed {
        logic Interrupt;
        logic WrongAddressinIF;
        logic ReservedInstruction;
        logic Overflow;
        logic Syscall;
        logic Break;
        logic RdWrongAddressinMEM;
        logic WrWrongAddressinMEM;
        logic Eret;
    } ExceptinPipeType;

    typedef enum logic {
        EXC_IDLE,
        EXC_REDIRECT
    } exc_state_t;

    localparam int unsigned STATUS_IE    = 0;
    localparam int unsigned STATUS_EXL   = 1;
    localparam int unsigned STATUS_IM_LO = 8;
    localparam int unsigned STATUS_IM_HI = 15;

    localparam logic [4:0] CP0_ADDR_STATUS = 5'd12;
    localparam logic [4:0] CP0_ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_ADDR_EPC    = 5'd14;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;

endpackage

// File: rtl/exception_unit_prioritizer.sv
// Fixed-priority pick of one exception from the gated flag set.
// The Interrupt field of flags already carries the resolved interrupt-pending state.
module exception_unit_prioritizer
    import exception_unit_pkg::*;
(
    input  ExceptinPipeType flags,
    output ExceptinPipeType winner,
    output logic            found,
    output logic            is_eret
);

    always_comb begin
        winner = '0;
        if (flags.Interrupt)                winner.Interrupt           = 1'b1;
        else if (flags.WrongAddressinIF)    winner.WrongAddressinIF    = 1'b1;
        else if (flags.ReservedInstruction) winner.ReservedInstruction = 1'b1;
        else if (flags.Overflow)            winner.Overflow            = 1'b1;
        else if (flags.Syscall)             winner.Syscall             = 1'b1;
        else if (flags.Break)               winner.Break               = 1'b1;
        else if (flags.RdWrongAddressinMEM) winner.RdWrongAddressinMEM = 1'b1;
        else if (flags.WrWrongAddressinMEM) winner.WrWrongAddressinMEM = 1'b1;
        else if (flags.Eret)                winner.Eret                = 1'b1;
        found   = |winner;
        is_eret = winner.Eret;
    end

endmodule

// File: rtl/exception_unit.sv
// MEM-stage exception arbiter: forwards in-flight mtc0 writes, resolves interrupts,
// hands one winner to CP0 for a cycle and holds a valid/ready redirect to IF.
module exception_unit
    import exception_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int unsigned TIMER_IP_BIT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemValid_i,
    input  ExceptinPipeType ExceptType_i,
    input  logic [31:0]     MemPC_i,
    input  logic            IsDelaySlot_i,
    input  logic [31:0]     MemVAddr_i,
    input  logic [31:0]     CP0Status_i,
    input  logic [31:0]     CP0Cause_i,
    input  logic [31:0]     CP0EPC_i,
    input  logic            CP0TimerInterrupt_i,
    input  logic            CP0Wr_i,
    input  logic [4:0]      CP0WrAddr_i,
    input  logic [31:0]     CP0WrData_i,
    input  logic            RedirectReady_i,
    output ExceptinPipeType ExceptTypeFinal_o,
    output logic            IsDelaySlot_o,
    output logic [31:0]     PCAdd4_o,
    output logic [31:0]     VirtualAddr_o,
    output logic            Flush_o,
    output logic            RedirectValid_o,
    output logic [31:0]     RedirectPC_o,
    output logic            Stall_o
);

    localparam logic [31:0] TIMER_MASK = 32'(1) << TIMER_IP_BIT;

    exc_state_t      state;
    logic [31:0]     eff_status;
    logic [31:0]     eff_cause;
    logic [31:0]     eff_epc;
    logic [31:0]     cause_ip;
    logic            int_pending;
    logic            accept;
    ExceptinPipeType gated;
    ExceptinPipeType winner;
    logic            found;
    logic            is_eret;
    logic            unused_bits;

    // Only Cause.IP[1:0] (software interrupts) are writable by mtc0, so only they forward.
    always_comb begin
        eff_status = (CP0Wr_i && CP0WrAddr_i == CP0_ADDR_STATUS) ? CP0WrData_i : CP0Status_i;
        eff_epc    = (CP0Wr_i && CP0WrAddr_i == CP0_ADDR_EPC)    ? CP0WrData_i : CP0EPC_i;
        eff_cause  = CP0Cause_i;
        if (CP0Wr_i && CP0WrAddr_i == CP0_ADDR_CAUSE)
            eff_cause[9:8] = CP0WrData_i[9:8];
        cause_ip = eff_cause | (CP0TimerInterrupt_i ? TIMER_MASK : '0);

        accept      = MemValid_i && (state == EXC_IDLE);
        int_pending = (|(cause_ip[STATUS_IM_HI:STATUS_IM_LO] & eff_status[STATUS_IM_HI:STATUS_IM_LO]))
                      && eff_status[STATUS_IE] && !eff_status[STATUS_EXL];

        gated           = accept ? ExceptType_i : '0;
        gated.Interrupt = accept && int_pending;
    end

    assign unused_bits = ^{eff_status[31:16], eff_status[7:2], cause_ip[31:16], cause_ip[7:0],
                           ExceptType_i.Interrupt};

    exception_unit_prioritizer u_prio (
        .flags   (gated),
        .winner  (winner),
        .found   (found),
        .is_eret (is_eret)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= EXC_IDLE;
            ExceptTypeFinal_o <= '0;
            IsDelaySlot_o     <= 1'b0;
            PCAdd4_o          <= '0;
            VirtualAddr_o     <= '0;
            Flush_o           <= 1'b0;
            RedirectValid_o   <= 1'b0;
            RedirectPC_o      <= '0;
            Stall_o           <= 1'b0;
        end else begin
            case (state)
                EXC_IDLE: begin
                    ExceptTypeFinal_o <= winner;
                    Flush_o           <= found;
                    if (found) begin
                        IsDelaySlot_o   <= IsDelaySlot_i;
                        PCAdd4_o        <= MemPC_i + 32'd4;
                        VirtualAddr_o   <= winner.WrongAddressinIF ? MemPC_i : MemVAddr_i;
                        RedirectValid_o <= 1'b1;
                        RedirectPC_o    <= is_eret ? eff_epc : EXC_VECTOR;
                        Stall_o         <= 1'b1;
                        state           <= EXC_REDIRECT;
                    end
                end
                EXC_REDIRECT: begin
                    ExceptTypeFinal_o <= '0;
                    Flush_o           <= 1'b0;
                    if (RedirectReady_i) begin
                        RedirectValid_o <= 1'b0;
                        RedirectPC_o    <= '0;
                        Stall_o         <= 1'b0;
                        state           <= EXC_IDLE;
                    end
                end
                default: state <= EXC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: expected outputs queued per step, checked after each edge.
module tb_exception_unit;
    import exception_unit_pkg::*;

    localparam logic [8:0] X_NONE = 9'h000;
    localparam logic [8:0] X_INT  = 9'h100;
    localparam logic [8:0] X_IF   = 9'h080;
    localparam logic [8:0] X_RI   = 9'h040;
    localparam logic [8:0] X_OV   = 9'h020;
    localparam logic [8:0] X_SYS  = 9'h010;
    localparam logic [8:0] X_BRK  = 9'h008;
    localparam logic [8:0] X_RD   = 9'h004;
    localparam logic [8:0] X_WR   = 9'h002;
    localparam logic [8:0] X_ERET = 9'h001;
    localparam logic [31:0] VEC   = 32'hBFC0_0380;

    logic            clk = 1'b0;
    logic            rst;
    logic            MemValid_i;
    ExceptinPipeType ExceptType_i;
    logic [31:0]     MemPC_i;
    logic            IsDelaySlot_i;
    logic [31:0]     MemVAddr_i;
    logic [31:0]     CP0Status_i;
    logic [31:0]     CP0Cause_i;
    logic [31:0]     CP0EPC_i;
    logic            CP0TimerInterrupt_i;
    logic            CP0Wr_i;
    logic [4:0]      CP0WrAddr_i;
    logic [31:0]     CP0WrData_i;
    logic            RedirectReady_i;
    ExceptinPipeType ExceptTypeFinal_o;
    logic            IsDelaySlot_o;
    logic [31:0]     PCAdd4_o;
    logic [31:0]     VirtualAddr_o;
    logic            Flush_o;
    logic            RedirectValid_o;
    logic [31:0]     RedirectPC_o;
    logic            Stall_o;

    typedef struct {
        logic [8:0]  exc;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic        stall;
        logic        chk_info;
        logic        ds;
        logic [31:0] pc4;
        logic [31:0] va;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    exception_unit #(
        .EXC_VECTOR   (32'hBFC0_0380),
        .TIMER_IP_BIT (15)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .MemValid_i          (MemValid_i),
        .ExceptType_i        (ExceptType_i),
        .MemPC_i             (MemPC_i),
        .IsDelaySlot_i       (IsDelaySlot_i),
        .MemVAddr_i          (MemVAddr_i),
        .CP0Status_i         (CP0Status_i),
        .CP0Cause_i          (CP0Cause_i),
        .CP0EPC_i            (CP0EPC_i),
        .CP0TimerInterrupt_i (CP0TimerInterrupt_i),
        .CP0Wr_i             (CP0Wr_i),
        .CP0WrAddr_i         (CP0WrAddr_i),
        .CP0WrData_i         (CP0WrData_i),
        .RedirectReady_i     (RedirectReady_i),
        .ExceptTypeFinal_o   (ExceptTypeFinal_o),
        .IsDelaySlot_o       (IsDelaySlot_o),
        .PCAdd4_o            (PCAdd4_o),
        .VirtualAddr_o       (VirtualAddr_o),
        .Flush_o             (Flush_o),
        .RedirectValid_o     (RedirectValid_o),
        .RedirectPC_o        (RedirectPC_o),
        .Stall_o             (Stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    task automatic expect_o(input logic [8:0] exc, input logic flush, input logic rv,
                            input logic [31:0] rpc, input logic stall, input logic chk_info,
                            input logic ds, input logic [31:0] pc4, input logic [31:0] va);
        exp_t e;
        e.exc = exc; e.flush = flush; e.rv = rv; e.rpc = rpc; e.stall = stall;
        e.chk_info = chk_info; e.ds = ds; e.pc4 = pc4; e.va = va;
        sb.push_back(e);
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk(tag, "except", {23'd0, ExceptTypeFinal_o}, {23'd0, e.exc});
            chk(tag, "flush",  {31'd0, Flush_o},           {31'd0, e.flush});
            chk(tag, "rvalid", {31'd0, RedirectValid_o},   {31'd0, e.rv});
            chk(tag, "rpc",    RedirectPC_o,               e.rpc);
            chk(tag, "stall",  {31'd0, Stall_o},           {31'd0, e.stall});
            if (e.chk_info) begin
                chk(tag, "dslot", {31'd0, IsDelaySlot_o}, {31'd0, e.ds});
                chk(tag, "pc4",   PCAdd4_o,               e.pc4);
                chk(tag, "vaddr", VirtualAddr_o,          e.va);
            end
        end
    endtask

    task automatic clear_inputs();
        MemValid_i = 1'b0; ExceptType_i = '0; MemPC_i = '0; IsDelaySlot_i = 1'b0;
        MemVAddr_i = '0; CP0Status_i = '0; CP0Cause_i = '0; CP0EPC_i = '0;
        CP0TimerInterrupt_i = 1'b0; CP0Wr_i = 1'b0; CP0WrAddr_i = '0; CP0WrData_i = '0;
        RedirectReady_i = 1'b0;
    endtask

    task automatic ack(input string tag);
        clear_inputs();
        RedirectReady_i = 1'b1;
        expect_o(X_NONE, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        step(tag);
        RedirectReady_i = 1'b0;
    endtask

    task automatic raise(input logic [8:0] exc, input logic [31:0] pc, input logic [31:0] va, input logic ds);
        MemValid_i = 1'b1; ExceptType_i = ExceptinPipeType'(exc);
        MemPC_i = pc; MemVAddr_i = va; IsDelaySlot_i = ds;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        expect_o(X_NONE, 0, 0, 32'h0, 0, 1, 0, 32'h0, 32'h0);
        step("reset");
        rst = 1'b0;

        // enabled hardware interrupt IP2
        raise(X_NONE, 32'h8000_0100, 32'h0000_1234, 1'b0);
        CP0Status_i = 32'h0000_FF01; CP0Cause_i = 32'h0000_0400;
        expect_o(X_INT, 1, 1, VEC, 1, 1, 0, 32'h8000_0104, 32'h0000_1234);
        step("irq");
        ack("irq_ack");

        raise(X_SYS | X_OV, 32'h0000_0400, 32'h0000_0010, 1'b1);
        expect_o(X_OV, 1, 1, VEC, 1, 1, 1, 32'h0000_0404, 32'h0000_0010);
        step("ov_over_sys");
        ack("ov_ack");

        raise(X_RD, 32'h0000_0500, 32'h0000_0003, 1'b0);
        expect_o(X_RD, 1, 1, VEC, 1, 1, 0, 32'h0000_0504, 32'h0000_0003);
        step("rd_addr");
        ack("rd_ack");

        raise(X_IF | X_RI, 32'h8000_0002, 32'h0000_0099, 1'b0);
        expect_o(X_IF, 1, 1, VEC, 1, 1, 0, 32'h8000_0006, 32'h8000_0002);
        step("if_addr");
        ack("if_ack");

        // eret with EPC forwarded from a same-cycle mtc0, then a slow IF
        raise(X_ERET, 32'h0000_0600, 32'h0, 1'b0);
        CP0EPC_i = 32'hDEAD_0000; CP0Wr_i = 1'b1; CP0WrAddr_i = 5'd14; CP0WrData_i = 32'h8000_0200;
        expect_o(X_ERET, 1, 1, 32'h8000_0200, 1, 1, 0, 32'h0000_0604, 32'h0);
        step("eret");
        clear_inputs();
        raise(X_BRK, 32'h0000_0700, 32'h0, 1'b0);
        expect_o(X_NONE, 0, 1, 32'h8000_0200, 1, 1, 0, 32'h0000_0604, 32'h0);
        step("hold1");
        clear_inputs();
        expect_o(X_NONE, 0, 1, 32'h8000_0200, 1, 0, 0, 32'h0, 32'h0);
        step("hold2");
        expect_o(X_NONE, 0, 1, 32'h8000_0200, 1, 0, 0, 32'h0, 32'h0);
        step("hold3");
        raise(X_BRK, 32'h0000_0700, 32'h0, 1'b0);
        RedirectReady_i = 1'b1;
        expect_o(X_NONE, 0, 0, 32'h0, 0, 1, 0, 32'h0000_0604, 32'h0);
        step("hold_ack");
        clear_inputs();
        expect_o(X_NONE, 0, 0, 32'h0, 0, 1, 0, 32'h0000_0604, 32'h0);
        step("break_dropped");

        raise(X_NONE, 32'h0000_0800, 32'h0, 1'b0);
        CP0Status_i = 32'h0000_FF03; CP0Cause_i = 32'h0000_0400;
        expect_o(X_NONE, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        step("exl_masks");
        CP0Status_i = 32'h0000_FF01;
        CP0Wr_i = 1'b1; CP0WrAddr_i = 5'd12; CP0WrData_i = 32'h0000_FF00;
        expect_o(X_NONE, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        step("mtc0_ie_off");
        CP0Wr_i = 1'b0;
        MemValid_i = 1'b0; ExceptType_i = ExceptinPipeType'(X_SYS);
        expect_o(X_NONE, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        step("invalid_gated");

        clear_inputs();
        raise(X_NONE, 32'h0000_0800, 32'h0000_0044, 1'b0);
        CP0Status_i = 32'h0000_8001; CP0TimerInterrupt_i = 1'b1;
        expect_o(X_INT, 1, 1, VEC, 1, 1, 0, 32'h0000_0804, 32'h0000_0044);
        step("timer_irq");
        ack("timer_ack");

        raise(X_BRK, 32'h0000_0900, 32'h0, 1'b0);
        CP0Status_i = 32'h0000_0101;
        CP0Wr_i = 1'b1; CP0WrAddr_i = 5'd13; CP0WrData_i = 32'h0000_0100;
        expect_o(X_INT, 1, 1, VEC, 1, 1, 0, 32'h0000_0904, 32'h0);
        step("sw_irq_fwd");
        ack("sw_ack");

        raise(X_WR, 32'hFFFF_FFFC, 32'h0000_0007, 1'b1);
        expect_o(X_WR, 1, 1, VEC, 1, 1, 1, 32'h0000_0000, 32'h0000_0007);
        step("wr_addr_wrap");
        clear_inputs();
        rst = 1'b1;
        expect_o(X_NONE, 0, 0, 32'h0, 0, 1, 0, 32'h0, 32'h0);
        step("rst_mid");
        rst = 1'b0;

        raise(X_ERET, 32'h0000_0A00, 32'h0, 1'b0);
        CP0EPC_i = 32'h8000_0300;
        expect_o(X_ERET, 1, 1, 32'h8000_0300, 1, 1, 0, 32'h0000_0A04, 32'h0);
        step("eret_after_rst");
        ack("eret_ack");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
